// File: rtl/req_encoder_4to2.sv
// 4-to-2 request encoder with a registered valid/ready grant handshake.
// PRIO_MODE selects fixed priority (0, index 3 highest) or round-robin (1).
module req_encoder_4to2 #(
  parameter int PRIO_MODE = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en_l,
  input  logic [3:0] i_req_l,
  input  logic       i_ready,
  output logic       o_valid,
  output logic       o_b,
  output logic       o_a,
  output logic       o_gs_l
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     r_state;
  logic [3:0] r_req_s;
  logic [1:0] r_ptr;
  logic       r_valid;
  logic       r_b;
  logic       r_a;
  logic       r_gs_l;

  logic [1:0] w_k;
  logic [1:0] w_idx;
  logic       w_any;

  // Later loop iterations overwrite earlier ones: in fixed mode the highest
  // set index wins; in round-robin the offsets run downwards, so the smallest
  // offset from the pointer wins.
  always_comb begin
    w_k   = 2'd0;
    w_idx = 2'd0;
    w_any = |r_req_s;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < 4; i++)
        if (r_req_s[i]) w_k = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--) begin
        w_idx = r_ptr + 2'(i);
        if (r_req_s[w_idx]) w_k = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_req_s <= 4'd0;
      r_ptr   <= 2'd0;
      r_valid <= 1'b0;
      r_b     <= 1'b0;
      r_a     <= 1'b0;
      r_gs_l  <= 1'b1;
    end else begin
      r_req_s <= ~i_req_l;
      r_gs_l  <= ~(~i_en_l & w_any);
      case (r_state)
        IDLE: begin
          if (!i_en_l && w_any) begin
            r_b     <= w_k[1];
            r_a     <= w_k[0];
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // the held grant ignores request and enable changes until accepted
          if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
            if (PRIO_MODE != 0) r_ptr <= {r_b, r_a} + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_b     = r_b;
  assign o_a     = r_a;
  assign o_gs_l  = r_gs_l;

endmodule
